// File: rtl/dnn_pkg.sv
// Shared definitions for the DNN datapath blocks: product width,
// 32-bit saturation limits and the one-hot state encoding of mac_ctrl.
package dnn_pkg;

    localparam int PROD_W = 64;

    localparam logic [31:0] SAT_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] SAT_MIN = 32'h8000_0000;

    typedef enum logic [3:0] {
        S_IDLE     = 4'b0001,
        S_ISSUE    = 4'b0010,
        S_WAIT_MUL = 4'b0100,
        S_OUT      = 4'b1000
    } mac_state_t;

endpackage

// File: rtl/mac_requant.sv
// Combinational re-quantiser: arithmetic right shift of the 64-bit
// accumulator, saturation to signed 32 bits, then optional ReLU.
module mac_requant
    import dnn_pkg::*;
#(
    parameter int OUT_SHIFT = 16,
    parameter bit RELU_EN   = 1'b1
) (
    input  logic [PROD_W-1:0] acc,
    output logic [31:0]       data
);

    logic signed [PROD_W-1:0] shifted;
    logic [31:0]              sat;

    // The shifted value fits in 32 bits exactly when bits 63..31 are all equal.
    always_comb begin
        shifted = $signed(acc) >>> OUT_SHIFT;
        sat     = shifted[31:0];
        if (!((shifted[PROD_W-1:31] == '0) || (shifted[PROD_W-1:31] == '1))) begin
            sat = shifted[PROD_W-1] ? SAT_MIN : SAT_MAX;
        end
        data = (RELU_EN && sat[31]) ? 32'd0 : sat;
    end

endmodule

// File: rtl/mac_ctrl.sv
// Dot-product sequencer: feeds operand pairs to the sequential multiplier,
// accumulates the products and emits a re-quantised sum per vector.
module mac_ctrl
    import dnn_pkg::*;
#(
    parameter int OUT_SHIFT = 16,
    parameter bit RELU_EN   = 1'b1,
    parameter int LEN_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_a,
    input  logic [31:0]       in_b,
    input  logic              in_last,
    output logic [31:0]       mul_a,
    output logic [31:0]       mul_b,
    output logic              mul_valid,
    input  logic              mul_ready,
    input  logic [63:0]       mul_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data,
    output logic [LEN_W-1:0]  out_len
);

    mac_state_t         state;
    mac_state_t         next_state;
    logic [PROD_W-1:0]  acc;
    logic [LEN_W-1:0]   cnt;
    logic               last_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:     if (in_valid)  next_state = S_ISSUE;
            S_ISSUE:                   next_state = S_WAIT_MUL;
            S_WAIT_MUL: if (mul_ready) next_state = last_r ? S_OUT : S_IDLE;
            S_OUT:      if (out_ready) next_state = S_IDLE;
            default:                   next_state = S_IDLE;
        endcase
    end

    // Handshake outputs decode the state only, so no input reaches them combinationally.
    assign in_ready  = (state == S_IDLE);
    assign mul_valid = (state == S_ISSUE);
    assign out_valid = (state == S_OUT);
    assign out_len   = cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            cnt    <= '0;
            mul_a  <= '0;
            mul_b  <= '0;
            last_r <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        mul_a  <= in_a;
                        mul_b  <= in_b;
                        last_r <= in_last;
                        cnt    <= cnt + LEN_W'(1);
                    end
                end
                S_WAIT_MUL: begin
                    if (mul_ready) begin
                        acc <= acc + mul_result;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        acc <= '0;
                        cnt <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    mac_requant #(
        .OUT_SHIFT (OUT_SHIFT),
        .RELU_EN   (RELU_EN)
    ) u_requant (
        .acc  (acc),
        .data (out_data)
    );

endmodule

// File: tb/tb_mac_ctrl.sv
// Bench for mac_ctrl: two instances (shift 0/no ReLU and defaults) share
// stimulus, each served by a behavioural multiplier with adjustable latency.
module tb_mac_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_last;
    logic        out_ready;
    logic        stray;
    int          mul_lat;

    logic [1:0]  in_ready;
    logic [1:0]  mul_valid;
    logic [1:0]  mul_ready;
    logic [1:0]  ready_m;
    logic [1:0]  out_valid;
    logic [31:0] mul_a [2];
    logic [31:0] mul_b [2];
    logic [31:0] out_data [2];
    logic [15:0] out_len [2];
    logic [63:0] mul_result [2];
    logic [63:0] res_m [2];
    logic [63:0] prod [2];
    logic [1:0]  busy;
    int          cnt_m [2];

    typedef struct packed {
        logic [31:0] data;
        logic [15:0] len;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        last;
        int          lat;
        logic [31:0] exp0;
        logic [31:0] exp1;
        logic [15:0] len;
    } vec_t;

    exp_t q0[$];
    exp_t q1[$];
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    mac_ctrl #(.OUT_SHIFT(0), .RELU_EN(1'b0), .LEN_W(16)) dut0 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready[0]),
        .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .mul_a(mul_a[0]), .mul_b(mul_b[0]), .mul_valid(mul_valid[0]),
        .mul_ready(mul_ready[0]), .mul_result(mul_result[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready),
        .out_data(out_data[0]), .out_len(out_len[0])
    );

    mac_ctrl dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready[1]),
        .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .mul_a(mul_a[1]), .mul_b(mul_b[1]), .mul_valid(mul_valid[1]),
        .mul_ready(mul_ready[1]), .mul_result(mul_result[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready),
        .out_data(out_data[1]), .out_len(out_len[1])
    );

    // Stray ready pulses carry a bogus product so a wrongly accepted one shows up in the sum.
    assign mul_ready = ready_m | {stray, stray};
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            mul_result[i] = stray ? 64'd1000 : res_m[i];
        end
    end

    // Multiplier model: samples operands on valid, pulses ready mul_lat cycles later.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            ready_m[i] <= 1'b0;
            if (rst) begin
                busy[i] <= 1'b0;
                res_m[i] <= '0;
            end else if (mul_valid[i]) begin
                busy[i]  <= 1'b1;
                cnt_m[i] <= mul_lat - 1;
                prod[i]  <= longint'($signed(mul_a[i])) * longint'($signed(mul_b[i]));
            end else if (busy[i]) begin
                if (cnt_m[i] == 0) begin
                    ready_m[i] <= 1'b1;
                    res_m[i]   <= prod[i];
                    busy[i]    <= 1'b0;
                end else begin
                    cnt_m[i] <= cnt_m[i] - 1;
                end
            end
        end
    end

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic pop_check(input int i);
        exp_t e;
        if (i == 0) begin
            if (q0.size() == 0) begin
                check_output("unexpected_out0", 1, 0);
                return;
            end
            e = q0.pop_front();
        end else begin
            if (q1.size() == 0) begin
                check_output("unexpected_out1", 1, 0);
                return;
            end
            e = q1.pop_front();
        end
        check_output($sformatf("out_data%0d", i), 64'(out_data[i]), 64'(e.data));
        check_output($sformatf("out_len%0d", i), 64'(out_len[i]), 64'(e.len));
    endtask

    // Scoreboard side: compare each result in the cycle its handshake completes.
    always @(negedge clk) begin
        if (!rst && out_ready) begin
            if (out_valid[0]) pop_check(0);
            if (out_valid[1]) pop_check(1);
        end
    end

    task automatic push_exp(input logic [31:0] d0, input logic [31:0] d1, input logic [15:0] len);
        q0.push_back('{data: d0, len: len});
        q1.push_back('{data: d1, len: len});
    endtask

    task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] b, input logic last);
        int n = 0;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        in_valid = 1'b1;
        while (!in_ready[0] && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready[0]) begin
            check_output("in_accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_output("in_ready_after_accept", 64'(in_ready[0]), 0);
    endtask

    task automatic drain();
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        check_output("drain_q0", 64'(q0.size()), 0);
        check_output("drain_q1", 64'(q1.size()), 0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t tbl [10];
        int   mv;
        int   ir;
        int   cyc;
        int   n;

        tbl[0] = '{32'd2,          32'd5,          1'b0, 64, 32'h0,         32'h0,         16'd0};
        tbl[1] = '{32'hFFFF_FFFF,  32'd7,          1'b0, 3,  32'h0,         32'h0,         16'd0};
        tbl[2] = '{32'd10,         32'd10,         1'b1, 1,  32'h0000_0067, 32'h0,         16'd3};
        tbl[3] = '{32'h7FFF_FFFF,  32'h7FFF_FFFF,  1'b0, 2,  32'h0,         32'h0,         16'd0};
        tbl[4] = '{32'h7FFF_FFFF,  32'h7FFF_FFFF,  1'b1, 5,  32'h7FFF_FFFF, 32'h7FFF_FFFF, 16'd2};
        tbl[5] = '{32'h8000_0000,  32'h7FFF_FFFF,  1'b1, 4,  32'h8000_0000, 32'h0,         16'd1};
        tbl[6] = '{32'h0001_0000,  32'h0003_0000,  1'b1, 64, 32'h7FFF_FFFF, 32'h0003_0000, 16'd1};
        tbl[7] = '{32'hFFFF_FFFB,  32'd3,          1'b1, 2,  32'hFFFF_FFF1, 32'h0,         16'd1};
        tbl[8] = '{32'h0001_2345,  32'h0001_0000,  1'b1, 7,  32'h7FFF_FFFF, 32'h0001_2345, 16'd1};
        tbl[9] = '{32'hFFFF_0000,  32'h0002_0000,  1'b1, 1,  32'h8000_0000, 32'h0,         16'd1};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        stray     = 1'b0;
        mul_lat   = 64;
        repeat (3) @(posedge clk);
        #1;
        check_output("rst_in_ready", 64'(in_ready[0]), 1);
        check_output("rst_out_valid", 64'(out_valid), 0);
        check_output("rst_mul_valid", 64'(mul_valid), 0);
        check_output("rst_mul_a", 64'(mul_a[0]), 0);
        check_output("rst_mul_b", 64'(mul_b[0]), 0);
        check_output("rst_out_len", 64'(out_len[0]), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Single pair at nominal latency: one issue pulse, result 66 cycles after acceptance.
        mul_lat = 64;
        push_exp(32'hFFFF_FFF4, 32'h0, 16'd1);
        apply_stimulus(32'd3, 32'hFFFF_FFFC, 1'b1);
        mv  = 0;
        ir  = 0;
        cyc = 0;
        while (!out_valid[0] && cyc < 300) begin
            if (mul_valid[0]) mv++;
            if (in_ready[0]) ir++;
            @(posedge clk); #1;
            cyc++;
        end
        check_output("mul_valid_cycles", 64'(mv), 1);
        check_output("in_ready_while_busy", 64'(ir), 0);
        check_output("out_latency", 64'(cyc), 66);
        drain();

        for (int i = 0; i < 10; i++) begin
            mul_lat = tbl[i].lat;
            apply_stimulus(tbl[i].a, tbl[i].b, tbl[i].last);
            if (tbl[i].last) begin
                push_exp(tbl[i].exp0, tbl[i].exp1, tbl[i].len);
                drain();
            end
        end

        // Output backpressure with a pending input pair.
        out_ready = 1'b0;
        mul_lat   = 3;
        push_exp(32'd9, 32'd0, 16'd1);
        apply_stimulus(32'd1, 32'd9, 1'b1);
        n = 0;
        while (!out_valid[0] && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check_output("bp_out_valid_seen", 64'(out_valid[0]), 1);
        in_a     = 32'd4;
        in_b     = 32'd4;
        in_last  = 1'b1;
        in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            check_output("bp_out_valid", 64'(out_valid), 64'(2'b11));
            check_output("bp_out_data0", 64'(out_data[0]), 9);
            check_output("bp_out_len0", 64'(out_len[0]), 1);
            check_output("bp_in_ready", 64'(in_ready), 0);
            @(posedge clk); #1;
        end
        push_exp(32'd16, 32'd0, 16'd1);
        out_ready = 1'b1;
        n = 0;
        while (!in_ready[0] && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check_output("bp_in_ready_return", 64'(in_ready[0]), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        drain();

        // Reset while waiting on the multiplier, then a stray ready in IDLE.
        mul_lat = 64;
        apply_stimulus(32'd100, 32'd100, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_output("abort_out_valid", 64'(out_valid), 0);
        check_output("abort_mul_valid", 64'(mul_valid), 0);
        check_output("abort_in_ready", 64'(in_ready), 64'(2'b11));
        check_output("abort_out_len", 64'(out_len[0]), 0);
        repeat (3) @(posedge clk);
        #1;
        stray = 1'b1;
        @(posedge clk); #1;
        stray = 1'b0;
        check_output("stray_in_ready", 64'(in_ready[0]), 1);
        check_output("stray_out_valid", 64'(out_valid), 0);
        push_exp(32'd42, 32'd0, 16'd1);
        apply_stimulus(32'd6, 32'd7, 1'b1);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
